// File: rtl/cp0_if.sv
// cp0_if: write-back stage <-> CP0 register file connection.
//
// master (WB side) drives read address, mtc0 commits, exception/eret commits,
// tlbp result commits and the external interrupt lines; it receives read data,
// the architectural register copies and the interrupt-pending flag.
// slave (cp0_regfile) is the mirror image.
//
// Handshake: there is no valid/ready pair. Every *_we / wb_ex / eret strobe is
// already qualified by WB and commits unconditionally on the clock edge at
// which it is high; reads are purely combinational from raddr.
interface cp0_if #(
    parameter int INDEX_W = 4
);
    logic [4:0]         raddr;
    logic [31:0]        rdata;
    logic               mtc0_we;
    logic [4:0]         mtc0_addr;
    logic [31:0]        mtc0_wdata;
    logic               wb_ex;
    logic [4:0]         ex_code;
    logic               ex_bd;
    logic [31:0]        ex_pc;
    logic               ex_badv_we;
    logic [31:0]        ex_badvaddr;
    logic               eret;
    logic [5:0]         ext_int;
    logic               tlbp_we;
    logic               tlbp_found;
    logic [INDEX_W-1:0] tlbp_index;
    logic [31:0]        status_o;
    logic [31:0]        cause_o;
    logic [31:0]        epc_o;
    logic [31:0]        entryhi_o;
    logic               int_pending;

    modport master (
        output raddr, mtc0_we, mtc0_addr, mtc0_wdata,
        output wb_ex, ex_code, ex_bd, ex_pc, ex_badv_we, ex_badvaddr,
        output eret, ext_int, tlbp_we, tlbp_found, tlbp_index,
        input  rdata, status_o, cause_o, epc_o, entryhi_o, int_pending
    );

    modport slave (
        input  raddr, mtc0_we, mtc0_addr, mtc0_wdata,
        input  wb_ex, ex_code, ex_bd, ex_pc, ex_badv_we, ex_badvaddr,
        input  eret, ext_int, tlbp_we, tlbp_found, tlbp_index,
        output rdata, status_o, cause_o, epc_o, entryhi_o, int_pending
    );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 register file sitting beside the WB stage.
//
// Holds Index(0), BadVAddr(8), Count(9), EntryHi(10), Compare(11), Status(12),
// Cause(13) and EPC(14). Generates the timer interrupt (Cause.TI) and the
// combined interrupt-pending flag WB uses to raise an INT exception.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset; overrides every write that cycle
//   bus    - cp0_if.slave: read port, mtc0/exception/eret/tlbp commits,
//            ext_int lines, register copies and int_pending
module cp0_regfile #(
    parameter int INDEX_W = 4
) (
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);
    localparam logic [4:0] ADDR_INDEX    = 5'd0;
    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_ENTRYHI  = 5'd10;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    // Architectural state, stored as fields only
    logic               r_tick;
    logic [31:0]        r_count;
    logic [31:0]        r_compare;
    logic               r_ti;
    logic [7:0]         r_ip;
    logic               r_bd;
    logic [4:0]         r_exccode;
    logic [7:0]         r_im;
    logic               r_exl;
    logic               r_ie;
    logic [31:0]        r_epc;
    logic [31:0]        r_badv;
    logic [18:0]        r_vpn2;
    logic [7:0]         r_asid;
    logic               r_p;
    logic [INDEX_W-1:0] r_index;

    logic        w_wr_index;
    logic        w_wr_count;
    logic        w_wr_entryhi;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [31:0] w_ex_epc;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_entryhi;
    logic [31:0] w_index;

    assign w_wr_index   = bus.mtc0_we && (bus.mtc0_addr == ADDR_INDEX);
    assign w_wr_count   = bus.mtc0_we && (bus.mtc0_addr == ADDR_COUNT);
    assign w_wr_entryhi = bus.mtc0_we && (bus.mtc0_addr == ADDR_ENTRYHI);
    assign w_wr_compare = bus.mtc0_we && (bus.mtc0_addr == ADDR_COMPARE);
    assign w_wr_status  = bus.mtc0_we && (bus.mtc0_addr == ADDR_STATUS);
    assign w_wr_cause   = bus.mtc0_we && (bus.mtc0_addr == ADDR_CAUSE);
    assign w_wr_epc     = bus.mtc0_we && (bus.mtc0_addr == ADDR_EPC);

    // A delay-slot fault restarts at the branch, one word earlier
    assign w_ex_epc = bus.ex_bd ? (bus.ex_pc - 32'd4) : bus.ex_pc;

    // Status.BEV (bit 22) is hardwired to 1
    assign w_status  = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause   = {r_bd, r_ti, 14'd0, r_ip, 1'b0, r_exccode, 2'b00};
    assign w_entryhi = {r_vpn2, 5'd0, r_asid};
    assign w_index   = {r_p, {(31-INDEX_W){1'b0}}, r_index};

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.raddr)
            ADDR_INDEX:    bus.rdata = w_index;
            ADDR_BADVADDR: bus.rdata = r_badv;
            ADDR_COUNT:    bus.rdata = r_count;
            ADDR_ENTRYHI:  bus.rdata = w_entryhi;
            ADDR_COMPARE:  bus.rdata = r_compare;
            ADDR_STATUS:   bus.rdata = w_status;
            ADDR_CAUSE:    bus.rdata = w_cause;
            ADDR_EPC:      bus.rdata = r_epc;
            default:       bus.rdata = 32'd0;
        endcase
    end

    assign bus.status_o    = w_status;
    assign bus.cause_o     = w_cause;
    assign bus.epc_o       = r_epc;
    assign bus.entryhi_o   = w_entryhi;
    assign bus.int_pending = (|(r_ip & r_im)) && r_ie && !r_exl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick    <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
            r_ip      <= 8'd0;
            r_bd      <= 1'b0;
            r_exccode <= 5'd0;
            r_im      <= 8'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_epc     <= 32'd0;
            r_badv    <= 32'd0;
            r_vpn2    <= 19'd0;
            r_asid    <= 8'd0;
            r_p       <= 1'b0;
            r_index   <= '0;
        end else begin
            // Count advances at half the core clock rate
            r_tick <= ~r_tick;
            if (w_wr_count) begin
                r_count <= bus.mtc0_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end

            // TI is sticky until software rewrites Compare
            if (w_wr_compare) begin
                r_compare <= bus.mtc0_wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end

            // Hardware IP bits are resampled every cycle; the timer shares IP7
            r_ip[7:2] <= {bus.ext_int[5] | r_ti, bus.ext_int[4:0]};
            if (w_wr_cause) begin
                r_ip[1:0] <= bus.mtc0_wdata[9:8];
            end

            // An exception commit owns EXL/EPC/Status; nested exceptions
            // (EXL already set) keep the original BD and EPC
            if (bus.wb_ex) begin
                r_exccode <= bus.ex_code;
                r_exl     <= 1'b1;
                if (!r_exl) begin
                    r_bd  <= bus.ex_bd;
                    r_epc <= w_ex_epc;
                end
            end else begin
                if (w_wr_status) begin
                    r_im  <= bus.mtc0_wdata[15:8];
                    r_exl <= bus.mtc0_wdata[1];
                    r_ie  <= bus.mtc0_wdata[0];
                end
                // Placed after the mtc0 write so eret wins for EXL
                if (bus.eret) begin
                    r_exl <= 1'b0;
                end
                if (w_wr_epc) begin
                    r_epc <= bus.mtc0_wdata;
                end
            end

            if (bus.wb_ex && bus.ex_badv_we) begin
                r_badv <= bus.ex_badvaddr;
            end

            if (w_wr_entryhi) begin
                r_vpn2 <= bus.mtc0_wdata[31:13];
                r_asid <= bus.mtc0_wdata[7:0];
            end

            // tlbp result takes precedence over a software Index write
            if (bus.tlbp_we) begin
                r_p <= ~bus.tlbp_found;
                if (bus.tlbp_found) begin
                    r_index <= bus.tlbp_index;
                end
            end else if (w_wr_index) begin
                r_index <= bus.mtc0_wdata[INDEX_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed bench for cp0_regfile with a word-level reference
// model and a per-cycle comparison of every output.
module tb_cp0_regfile;
  localparam int INDEX_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_if #(.INDEX_W(INDEX_W)) bus ();

  cp0_regfile #(.INDEX_W(INDEX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model (whole-word registers) ----------------
  logic [31:0] m_index, m_badv, m_count, m_entryhi, m_compare;
  logic [31:0] m_status, m_cause, m_epc;
  logic        m_tick;
  logic [31:0] idx_mask;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd0:    return m_index;
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd10:   return m_entryhi;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int();
    return (|(m_cause[15:8] & m_status[15:8])) && m_status[0] && !m_status[1];
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic mdl_step();
    logic [31:0] n_index, n_badv, n_count, n_entryhi, n_compare;
    logic [31:0] n_status, n_cause, n_epc;
    logic        wr, exl;
    if (reset) begin
      m_index = 0; m_badv = 0; m_count = 0; m_entryhi = 0; m_compare = 0;
      m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_tick = 0;
      return;
    end
    wr = bus.mtc0_we;
    exl = m_status[1];
    n_index = m_index; n_badv = m_badv; n_count = m_count; n_entryhi = m_entryhi;
    n_compare = m_compare; n_status = m_status; n_cause = m_cause; n_epc = m_epc;

    if (wr && bus.mtc0_addr == 5'd9) n_count = bus.mtc0_wdata;
    else if (m_tick) n_count = m_count + 32'd1;

    if (wr && bus.mtc0_addr == 5'd11) begin
      n_compare = bus.mtc0_wdata;
      n_cause[30] = 1'b0;
    end else if (m_count == m_compare) begin
      n_cause[30] = 1'b1;
    end

    n_cause[15] = bus.ext_int[5] | m_cause[30];
    n_cause[14:10] = bus.ext_int[4:0];
    if (wr && bus.mtc0_addr == 5'd13) n_cause[9:8] = bus.mtc0_wdata[9:8];

    if (bus.wb_ex) begin
      n_cause[6:2] = bus.ex_code;
      n_status[1] = 1'b1;
      if (!exl) begin
        n_cause[31] = bus.ex_bd;
        n_epc = bus.ex_bd ? bus.ex_pc - 32'd4 : bus.ex_pc;
      end
      if (bus.ex_badv_we) n_badv = bus.ex_badvaddr;
    end else begin
      if (wr && bus.mtc0_addr == 5'd12) n_status = (bus.mtc0_wdata & 32'h0000_FF03) | 32'h0040_0000;
      if (bus.eret) n_status[1] = 1'b0;
      if (wr && bus.mtc0_addr == 5'd14) n_epc = bus.mtc0_wdata;
    end

    if (wr && bus.mtc0_addr == 5'd10) n_entryhi = bus.mtc0_wdata & 32'hFFFF_E0FF;

    if (bus.tlbp_we) begin
      n_index[31] = ~bus.tlbp_found;
      if (bus.tlbp_found) n_index = (n_index & ~idx_mask) | (32'(bus.tlbp_index) & idx_mask);
    end else if (wr && bus.mtc0_addr == 5'd0) begin
      n_index = (m_index & ~idx_mask) | (bus.mtc0_wdata & idx_mask);
    end

    m_index = n_index; m_badv = n_badv; m_count = n_count; m_entryhi = n_entryhi;
    m_compare = n_compare; m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    m_tick = ~m_tick;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One compare process: every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("status_o", bus.status_o, m_status);
      chk("cause_o", bus.cause_o, m_cause);
      chk("epc_o", bus.epc_o, m_epc);
      chk("entryhi_o", bus.entryhi_o, m_entryhi);
      chk("int_pending", {31'd0, bus.int_pending}, {31'd0, m_int()});
      chk("rdata", bus.rdata, m_read(bus.raddr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clk_cycle();
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  task automatic clear_strobes();
    bus.mtc0_we = 0; bus.wb_ex = 0; bus.eret = 0;
    bus.tlbp_we = 0; bus.ex_badv_we = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.mtc0_we = 1; bus.mtc0_addr = a; bus.mtc0_wdata = d;
    clk_cycle();
    clear_strobes();
  endtask

  task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                     input logic bv_we, input logic [31:0] bv);
    bus.wb_ex = 1; bus.ex_code = code; bus.ex_bd = bd; bus.ex_pc = pc;
    bus.ex_badv_we = bv_we; bus.ex_badvaddr = bv;
    clk_cycle();
    clear_strobes();
  endtask

  task automatic do_eret();
    bus.eret = 1;
    clk_cycle();
    clear_strobes();
  endtask

  task automatic tlbp(input logic found, input logic [INDEX_W-1:0] idx);
    bus.tlbp_we = 1; bus.tlbp_found = found; bus.tlbp_index = idx;
    clk_cycle();
    clear_strobes();
  endtask

  // Hand-computed literal read check
  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string name);
    bus.raddr = a;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idx_mask = (32'd1 << INDEX_W) - 32'd1;
    m_tick = 0;
    bus.raddr = 0; bus.mtc0_addr = 0; bus.mtc0_wdata = 0;
    bus.ex_code = 0; bus.ex_bd = 0; bus.ex_pc = 0; bus.ex_badvaddr = 0;
    bus.ext_int = 0; bus.tlbp_found = 0; bus.tlbp_index = 0;
    clear_strobes();
    reset = 1;
    clk_cycle();
    clk_cycle();
    reset = 0;
    chk_en = 1;

    // Reset state
    peek(5'd12, 32'h0040_0000, "rst_status");
    peek(5'd13, 32'h0000_0000, "rst_cause");
    peek(5'd14, 32'h0000_0000, "rst_epc");
    chk("rst_int", {31'd0, bus.int_pending}, 32'd0);

    // Park Compare far away so the timer stays quiet
    mtc0(5'd11, 32'h0000_1000);
    clk_cycle(); clk_cycle();

    // External interrupt, exception entry and eret
    bus.ext_int = 6'b100000;
    mtc0(5'd12, 32'h0000_8001);
    peek(5'd12, 32'h0040_8001, "status_wr");
    chk("int_on", {31'd0, bus.int_pending}, 32'd1);
    exc(5'd0, 1'b0, 32'hBFC0_0100, 1'b0, 32'd0);
    chk("epc_int", bus.epc_o, 32'hBFC0_0100);
    peek(5'd12, 32'h0040_8003, "exl_set");
    chk("int_masked", {31'd0, bus.int_pending}, 32'd0);
    do_eret();
    peek(5'd12, 32'h0040_8001, "exl_clr");
    bus.ext_int = 0;
    clk_cycle(); clk_cycle();

    // Delay-slot exception with bad address, then nested exception
    exc(5'd4, 1'b1, 32'h8000_0010, 1'b1, 32'h0000_0003);
    peek(5'd14, 32'h8000_000C, "epc_bd");
    peek(5'd13, 32'h8000_0010, "cause_bd");
    peek(5'd8, 32'h0000_0003, "badvaddr");
    exc(5'd8, 1'b0, 32'h0000_1234, 1'b0, 32'd0);
    peek(5'd14, 32'h8000_000C, "epc_nested");
    peek(5'd13, 32'h8000_0020, "cause_nested");
    do_eret();

    // Timer interrupt
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    begin
      int n;
      n = 0;
      while (m_count != 32'd5 && n < 40) begin
        clk_cycle();
        n++;
      end
      if (m_count != 32'd5) chk("count_reach_bound", m_count, 32'd5);
    end
    clk_cycle();
    chk("ti_set", {31'd0, bus.cause_o[30]}, 32'd1);
    clk_cycle();
    chk("ip7_ti", {31'd0, bus.cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'd100);
    chk("ti_clr", {31'd0, bus.cause_o[30]}, 32'd0);

    // Count wrap and write-over-increment
    mtc0(5'd9, 32'hFFFF_FFFF);
    clk_cycle(); clk_cycle();
    peek(5'd9, 32'h0000_0000, "count_wrap");
    if (m_tick != 1'b1) clk_cycle();
    mtc0(5'd9, 32'h0000_0010);
    peek(5'd9, 32'h0000_0010, "count_wr_tick");

    // tlbp / Index
    tlbp(1'b1, 4'd7);
    peek(5'd0, 32'h0000_0007, "tlbp_hit");
    tlbp(1'b0, 4'd2);
    peek(5'd0, 32'h8000_0007, "tlbp_miss");
    bus.tlbp_we = 1; bus.tlbp_found = 1; bus.tlbp_index = 4'd3;
    mtc0(5'd0, 32'd9);
    peek(5'd0, 32'h0000_0003, "tlbp_over_mtc0");
    mtc0(5'd0, 32'hFFFF_FFF5);
    peek(5'd0, 32'h0000_0005, "index_wr");

    // EntryHi masking, unmapped and read-only registers
    mtc0(5'd10, 32'hFFFF_FFFF);
    peek(5'd10, 32'hFFFF_E0FF, "entryhi");
    mtc0(5'd5, 32'h0000_1234);
    peek(5'd5, 32'h0000_0000, "unmapped");
    mtc0(5'd8, 32'h0000_DEAD);
    peek(5'd8, 32'h0000_0003, "badv_ro");
    mtc0(5'd14, 32'h1111_2220);
    peek(5'd14, 32'h1111_2220, "epc_wr");

    // Same-cycle priority: exception beats mtc0 EPC, eret beats mtc0 EXL
    bus.mtc0_we = 1; bus.mtc0_addr = 5'd14; bus.mtc0_wdata = 32'hAAAA_0000;
    exc(5'd1, 1'b0, 32'h0000_2000, 1'b0, 32'd0);
    peek(5'd14, 32'h0000_2000, "epc_prio");
    bus.eret = 1;
    mtc0(5'd12, 32'h0000_8003);
    peek(5'd12, 32'h0040_8001, "eret_prio");

    // Reset during a write
    reset = 1;
    mtc0(5'd12, 32'h0000_FF03);
    reset = 0;
    peek(5'd12, 32'h0040_0000, "rst_mid_status");
    peek(5'd14, 32'h0000_0000, "rst_mid_epc");
    peek(5'd0, 32'h0000_0000, "rst_mid_index");
    clk_cycle(); clk_cycle(); clk_cycle();

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
